// File: rtl/stall_ctrl_pkg.sv
// Shared opcode/funct constants, instruction classes and Tuse/Tnew rules
// for the hazard and stall controller.
package stall_ctrl_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 6;
    localparam int unsigned T_W   = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [OPC_W-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OPC_W-1:0] OP_JAL     = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ     = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE     = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDIU   = 6'h09;
    localparam logic [OPC_W-1:0] OP_ORI     = 6'h0d;
    localparam logic [OPC_W-1:0] OP_LUI     = 6'h0f;
    localparam logic [OPC_W-1:0] OP_LW      = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW      = 6'h2b;

    localparam logic [OPC_W-1:0] FN_SLL   = 6'h00;
    localparam logic [OPC_W-1:0] FN_JR    = 6'h08;
    localparam logic [OPC_W-1:0] FN_JALR  = 6'h09;
    localparam logic [OPC_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [OPC_W-1:0] FN_MTHI  = 6'h11;
    localparam logic [OPC_W-1:0] FN_MFLO  = 6'h12;
    localparam logic [OPC_W-1:0] FN_MTLO  = 6'h13;
    localparam logic [OPC_W-1:0] FN_MULT  = 6'h18;
    localparam logic [OPC_W-1:0] FN_MULTU = 6'h19;
    localparam logic [OPC_W-1:0] FN_DIV   = 6'h1a;
    localparam logic [OPC_W-1:0] FN_DIVU  = 6'h1b;
    localparam logic [OPC_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [OPC_W-1:0] FN_SUBU  = 6'h23;
    localparam logic [OPC_W-1:0] FN_AND   = 6'h24;
    localparam logic [OPC_W-1:0] FN_OR    = 6'h25;
    localparam logic [OPC_W-1:0] FN_SLT   = 6'h2a;
    localparam logic [OPC_W-1:0] FN_SLTU  = 6'h2b;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LD, CLS_ST, CLS_BR,
        CLS_JR, CLS_JAL, CLS_JALR, CLS_MD, CLS_MF, CLS_MT
    } cls_e;

    // TUSE_NONE exceeds every Tnew, so a non-read can never stall
    localparam logic [T_W-1:0] T_0       = 2'd0;
    localparam logic [T_W-1:0] T_1       = 2'd1;
    localparam logic [T_W-1:0] T_2       = 2'd2;
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    localparam logic [CNT_W-1:0] MULT_CYC = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYC  = 4'd10;

    typedef struct packed {
        cls_e             cls;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
        logic             is_div;
    } dec_t;

    function automatic logic [T_W-1:0] tuse_rs(input cls_e c);
        case (c)
            CLS_BR, CLS_JR, CLS_JALR:                        return T_0;
            CLS_CAL_R, CLS_MD, CLS_CAL_I, CLS_LD, CLS_MT,
            CLS_ST:                                          return T_1;
            default:                                         return TUSE_NONE;
        endcase
    endfunction

    function automatic logic [T_W-1:0] tuse_rt(input cls_e c);
        case (c)
            CLS_BR:            return T_0;
            CLS_CAL_R, CLS_MD: return T_1;
            CLS_ST:            return T_2;
            default:           return TUSE_NONE;
        endcase
    endfunction

    function automatic logic [T_W-1:0] tnew_e(input cls_e c);
        case (c)
            CLS_CAL_R, CLS_CAL_I, CLS_MF: return T_1;
            CLS_LD:                       return T_2;
            default:                      return T_0;
        endcase
    endfunction

    function automatic logic [T_W-1:0] tnew_m(input cls_e c);
        return (c == CLS_LD) ? T_1 : T_0;
    endfunction

endpackage

// File: rtl/stall_ctrl_instr_class.sv
// Pure instruction decoder: IR to {class, rs, rt, destination, is_div}.
// A destination of 0 means "writes nothing".
module stall_ctrl_instr_class
    import stall_ctrl_pkg::*;
(
    input  logic [IR_W-1:0] ir_i,
    output dec_t            dec_o
);

    logic [OPC_W-1:0] op;
    logic [OPC_W-1:0] fn;
    cls_e             cls;
    logic             is_div;
    logic             unused_shamt;

    assign op           = ir_i[31:26];
    assign fn           = ir_i[5:0];
    assign unused_shamt = ^ir_i[10:6];

    always_comb begin
        cls    = CLS_NOP;
        is_div = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR,
                    FN_SLT, FN_SLTU, FN_SLL:       cls = CLS_CAL_R;
                    FN_JR:                         cls = CLS_JR;
                    FN_JALR:                       cls = CLS_JALR;
                    FN_MULT, FN_MULTU:             cls = CLS_MD;
                    FN_DIV, FN_DIVU: begin
                        cls    = CLS_MD;
                        is_div = 1'b1;
                    end
                    FN_MFHI, FN_MFLO:              cls = CLS_MF;
                    FN_MTHI, FN_MTLO:              cls = CLS_MT;
                    default:                       cls = CLS_NOP;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDIU: cls = CLS_CAL_I;
            OP_LW:                    cls = CLS_LD;
            OP_SW:                    cls = CLS_ST;
            OP_BEQ, OP_BNE:           cls = CLS_BR;
            OP_JAL:                   cls = CLS_JAL;
            default:                  cls = CLS_NOP;
        endcase
    end

    always_comb begin
        dec_o.cls    = cls;
        dec_o.rs     = ir_i[25:21];
        dec_o.rt     = ir_i[20:16];
        dec_o.is_div = is_div;
        dec_o.dst    = '0;
        case (cls)
            CLS_CAL_R, CLS_JALR, CLS_MF: dec_o.dst = ir_i[15:11];
            CLS_CAL_I, CLS_LD:           dec_o.dst = ir_i[20:16];
            CLS_JAL:                     dec_o.dst = REG_W'(31);
            default:                     dec_o.dst = '0;
        endcase
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: Tuse/Tnew RAW stalls on D vs E/M, plus an
// optional mult/div busy counter compiled in with `define MDU_STALL_EN.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IR_W-1:0] IR_D,
    input  logic [IR_W-1:0] IR_E,
    input  logic [IR_W-1:0] IR_M,
    output logic            En_PC,
    output logic            En_D,
    output logic            Clr_E,
    output logic            Busy
);

    dec_t dec_d;
    dec_t dec_e;
    dec_t dec_m;

    stall_ctrl_instr_class u_dec_d (.ir_i(IR_D), .dec_o(dec_d));
    stall_ctrl_instr_class u_dec_e (.ir_i(IR_E), .dec_o(dec_e));
    stall_ctrl_instr_class u_dec_m (.ir_i(IR_M), .dec_o(dec_m));

    logic [T_W-1:0] tuse_rs_d;
    logic [T_W-1:0] tuse_rt_d;
    logic [T_W-1:0] tnew_e_c;
    logic [T_W-1:0] tnew_m_c;
    logic           hz_rs_c;
    logic           hz_rt_c;
    logic           busy_c;
    logic           mdu_stall_c;
    logic           stall_c;

    assign tuse_rs_d = tuse_rs(dec_d.cls);
    assign tuse_rt_d = tuse_rt(dec_d.cls);
    assign tnew_e_c  = tnew_e(dec_e.cls);
    assign tnew_m_c  = tnew_m(dec_m.cls);

    // A non-writing stage reports dst 0, which the r != 0 term already excludes
    assign hz_rs_c = (dec_d.rs != '0) &&
                     (((dec_d.rs == dec_e.dst) && (tuse_rs_d < tnew_e_c)) ||
                      ((dec_d.rs == dec_m.dst) && (tuse_rs_d < tnew_m_c)));
    assign hz_rt_c = (dec_d.rt != '0) &&
                     (((dec_d.rt == dec_e.dst) && (tuse_rt_d < tnew_e_c)) ||
                      ((dec_d.rt == dec_m.dst) && (tuse_rt_d < tnew_m_c)));

`ifdef MDU_STALL_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             e_md_c;
    logic             unused_dec;

    assign e_md_c = (dec_e.cls == CLS_MD);

    always_comb begin
        cnt_d = cnt_q;
        if (e_md_c) begin
            cnt_d = dec_e.is_div ? DIV_CYC : MULT_CYC;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_c      = (cnt_q != '0) | e_md_c;
    assign mdu_stall_c = busy_c &
                         ((dec_d.cls == CLS_MD) | (dec_d.cls == CLS_MF) | (dec_d.cls == CLS_MT));
    assign unused_dec  = ^{dec_d.dst, dec_d.is_div, dec_e.rs, dec_e.rt,
                           dec_m.rs, dec_m.rt, dec_m.is_div};
`else
    logic unused_dec;

    assign busy_c      = 1'b0;
    assign mdu_stall_c = 1'b0;
    assign unused_dec  = ^{Clk, dec_d.dst, dec_d.is_div, dec_e.rs, dec_e.rt, dec_e.is_div,
                           dec_m.rs, dec_m.rt, dec_m.is_div};
`endif

    // Reset forces the free-running, non-stalled output state
    assign stall_c = ~Reset & (hz_rs_c | hz_rt_c | mdu_stall_c);
    assign En_PC   = ~stall_c;
    assign En_D    = ~stall_c;
    assign Clr_E   = stall_c;
    assign Busy    = ~Reset & busy_c;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed cases plus a randomized
// pipeline checked against a behavioural Tuse/Tnew and MDU-latency model.
module tb_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic [31:0] IR_M;
    logic        En_PC;
    logic        En_D;
    logic        Clr_E;
    logic        Busy;

    int checks = 0;
    int errors = 0;

`ifdef MDU_STALL_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    stall_ctrl dut (
        .Clk  (Clk),
        .Reset(Reset),
        .IR_D (IR_D),
        .IR_E (IR_E),
        .IR_M (IR_M),
        .En_PC(En_PC),
        .En_D (En_D),
        .Clr_E(Clr_E),
        .Busy (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int rs;
        int rt;
        int rs_use;   // -1: register not read
        int rt_use;
        int dst;      // -1: nothing written
        int tnew_e;
        int tnew_m;
        bit md;
        bit mdu_cls;
        int lat;
    } info_t;

    function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic info_t model_decode(input logic [31:0] ir);
        info_t x;
        x.rs = int'(ir[25:21]);  x.rt = int'(ir[20:16]);
        x.rs_use = -1; x.rt_use = -1; x.dst = -1;
        x.tnew_e = 0;  x.tnew_m = 0;  x.md = 1'b0; x.mdu_cls = 1'b0; x.lat = 0;
        if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00: begin
                    x.rs_use = 1; x.rt_use = 1; x.dst = int'(ir[15:11]); x.tnew_e = 1;
                end
                6'h08: x.rs_use = 0;
                6'h09: begin x.rs_use = 0; x.dst = int'(ir[15:11]); end
                6'h18, 6'h19: begin x.rs_use = 1; x.rt_use = 1; x.md = 1'b1; x.mdu_cls = 1'b1; x.lat = 5; end
                6'h1a, 6'h1b: begin x.rs_use = 1; x.rt_use = 1; x.md = 1'b1; x.mdu_cls = 1'b1; x.lat = 10; end
                6'h10, 6'h12: begin x.dst = int'(ir[15:11]); x.tnew_e = 1; x.mdu_cls = 1'b1; end
                6'h11, 6'h13: begin x.rs_use = 1; x.mdu_cls = 1'b1; end
                default: ;
            endcase
        end else begin
            case (ir[31:26])
                6'h0d, 6'h0f, 6'h09: begin x.rs_use = 1; x.dst = x.rt; x.tnew_e = 1; end
                6'h23: begin x.rs_use = 1; x.dst = x.rt; x.tnew_e = 2; x.tnew_m = 1; end
                6'h2b: begin x.rs_use = 1; x.rt_use = 2; end
                6'h04, 6'h05: begin x.rs_use = 0; x.rt_use = 0; end
                6'h03: x.dst = 31;
                default: ;
            endcase
        end
        return x;
    endfunction

    function automatic bit model_hazard(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        info_t di = model_decode(d);
        info_t ei = model_decode(e);
        info_t mi = model_decode(m);
        bit h = 1'b0;
        if (di.rs_use >= 0 && di.rs != 0) begin
            if (di.rs == ei.dst && di.rs_use < ei.tnew_e) h = 1'b1;
            if (di.rs == mi.dst && di.rs_use < mi.tnew_m) h = 1'b1;
        end
        if (di.rt_use >= 0 && di.rt != 0) begin
            if (di.rt == ei.dst && di.rt_use < ei.tnew_e) h = 1'b1;
            if (di.rt == mi.dst && di.rt_use < mi.tnew_m) h = 1'b1;
        end
        return h;
    endfunction

    function automatic int reg_pick();
        int v = int'($urandom_range(0, 4));
        return (v == 4) ? 31 : v;
    endfunction

    function automatic logic [31:0] rand_ins();
        int k  = int'($urandom_range(0, 21));
        int a  = reg_pick();
        int b  = reg_pick();
        int c  = reg_pick();
        int lo = int'($urandom_range(0, 1));
        case (k)
            0:  return r_ins(6'h21, a, b, c);
            1:  return r_ins(6'h23, a, b, c);
            2:  return r_ins(6'h24, a, b, c);
            3:  return r_ins(6'h25, a, b, c);
            4:  return r_ins(6'h2a, a, b, c);
            5:  return r_ins(6'h2b, a, b, c);
            6:  return r_ins(6'h00, 0, b, c);
            7:  return i_ins(6'h0d, a, b, 7);
            8:  return i_ins(6'h0f, 0, b, 3);
            9:  return i_ins(6'h09, a, b, 1);
            10: return i_ins(6'h23, a, b, 4);
            11: return i_ins(6'h2b, a, b, 8);
            12: return i_ins(6'h04, a, b, 2);
            13: return i_ins(6'h05, a, b, 2);
            14: return r_ins(6'h08, a, 0, 0);
            15: return i_ins(6'h03, 0, 0, 16);
            16: return r_ins(6'h09, a, 0, c);
            17: return r_ins(6'h18 + lo, a, b, 0);
            18: return r_ins(6'h1a + lo, a, b, 0);
            19: return r_ins(lo ? 6'h12 : 6'h10, 0, 0, c);
            20: return r_ins(lo ? 6'h13 : 6'h11, a, 0, 0);
            default: return i_ins(6'h3e, a, b, 0);
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        Reset = 1'b1;
        IR_M  = '0;
        IR_E  = i_ins(6'h23, 0, 1, 0);
        IR_D  = r_ins(6'h21, 1, 3, 2);
        tick();
        tick();
        @(negedge Clk);
        got = {En_PC, En_D, Clr_E, Busy};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL reset_forced {En_PC,En_D,Clr_E,Busy}=%b expected %b", got, 4'b1100);
        end
        tick();
        Reset = 1'b0;
        IR_D = '0; IR_E = '0; IR_M = '0;
        @(negedge Clk);
        got = {En_PC, En_D, Clr_E, Busy};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle {En_PC,En_D,Clr_E,Busy}=%b expected %b", got, 4'b1100);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] td [12];
        logic [31:0] te [12];
        logic [31:0] tm [12];
        bit          ts [12];
        logic [3:0]  got;
        logic [3:0]  exp;
        td[0]  = r_ins(6'h21, 1, 3, 2);   te[0]  = i_ins(6'h23, 0, 1, 0);   tm[0]  = '0; ts[0]  = 1;
        td[1]  = r_ins(6'h21, 1, 3, 2);   te[1]  = '0;   tm[1]  = i_ins(6'h23, 0, 1, 0); ts[1]  = 0;
        td[2]  = i_ins(6'h04, 1, 0, 0);   te[2]  = r_ins(6'h21, 2, 3, 1);   tm[2]  = '0; ts[2]  = 1;
        td[3]  = i_ins(6'h04, 1, 0, 0);   te[3]  = '0;   tm[3]  = r_ins(6'h21, 2, 3, 1); ts[3]  = 0;
        td[4]  = i_ins(6'h2b, 5, 4, 0);   te[4]  = i_ins(6'h23, 0, 4, 0);   tm[4]  = '0; ts[4]  = 0;
        td[5]  = i_ins(6'h2b, 4, 5, 0);   te[5]  = i_ins(6'h23, 0, 4, 0);   tm[5]  = '0; ts[5]  = 1;
        td[6]  = r_ins(6'h21, 0, 0, 2);   te[6]  = i_ins(6'h23, 0, 0, 0);   tm[6]  = '0; ts[6]  = 0;
        td[7]  = '0;                      te[7]  = '0;   tm[7]  = '0;                    ts[7]  = 0;
        td[8]  = r_ins(6'h08, 31, 0, 0);  te[8]  = i_ins(6'h03, 0, 0, 4);   tm[8]  = '0; ts[8]  = 0;
        td[9]  = i_ins(6'h04, 1, 0, 0);   te[9]  = '0;   tm[9]  = i_ins(6'h23, 0, 1, 0); ts[9]  = 1;
        td[10] = r_ins(6'h11, 7, 0, 0);   te[10] = i_ins(6'h0d, 0, 7, 1);   tm[10] = '0; ts[10] = 0;
        td[11] = i_ins(6'h04, 3, 0, 0);   te[11] = r_ins(6'h10, 0, 0, 3);   tm[11] = '0; ts[11] = 1;
        for (int i = 0; i < 12; i++) begin
            IR_D = td[i]; IR_E = te[i]; IR_M = tm[i];
            @(negedge Clk);
            got = {En_PC, En_D, Clr_E, Busy};
            exp = {~ts[i], ~ts[i], ts[i], 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL directed[%0d] {En_PC,En_D,Clr_E,Busy}=%b expected %b", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_mdu_latency(input bit is_div);
        int         lat = is_div ? 10 : 5;
        logic [3:0] got;
        logic [3:0] exp;
        bit         b;
        IR_M = '0;
        IR_E = r_ins(is_div ? 6'h1a : 6'h18, 1, 2, 0);
        IR_D = r_ins(6'h12, 0, 0, 2);
        for (int i = 0; i <= lat + 1; i++) begin
            @(negedge Clk);
            b   = MDU && (i <= lat);
            got = {En_PC, En_D, Clr_E, Busy};
            exp = {~b, ~b, b, b};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mdu_%s cycle %0d {En_PC,En_D,Clr_E,Busy}=%b expected %b",
                         is_div ? "div" : "mult", i, got, exp);
            end
            tick();
            IR_M = IR_E;
            IR_E = '0;
        end
        IR_D = '0; IR_M = '0;
        tick();
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] got;
        logic [3:0] exp;
        IR_M = '0; IR_D = '0;
        IR_E = r_ins(6'h1b, 1, 2, 0);
        tick();
        IR_E = '0;
        tick();
        tick();
        @(negedge Clk);
        got = {En_PC, En_D, Clr_E, Busy};
        exp = {3'b110, MDU};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_count_busy {En_PC,En_D,Clr_E,Busy}=%b expected %b", got, exp);
        end
        tick();
        Reset = 1'b1;
        IR_D  = r_ins(6'h12, 0, 0, 2);
        @(negedge Clk);
        got = {En_PC, En_D, Clr_E, Busy};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL mid_count_in_reset {En_PC,En_D,Clr_E,Busy}=%b expected %b", got, 4'b1100);
        end
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        got = {En_PC, En_D, Clr_E, Busy};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL mid_count_after_reset {En_PC,En_D,Clr_E,Busy}=%b expected %b", got, 4'b1100);
        end
        tick();
        IR_D = '0;
    endtask

    task automatic test_random_pipeline();
        logic [31:0] d = '0;
        logic [31:0] e = '0;
        logic [31:0] m = '0;
        int          busy_end = -1;
        bit          rst;
        bit          exp_busy;
        bit          exp_stall;
        info_t       di;
        info_t       ei;
        logic [3:0]  got;
        logic [3:0]  exp;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst   = ($urandom_range(0, 63) == 0);
            Reset = rst;
            IR_D = d; IR_E = e; IR_M = m;
            di = model_decode(d);
            ei = model_decode(e);
            // MDU busy spans the cycle an md sits in E plus its latency
            exp_busy  = MDU && !rst && (ei.md || cyc <= busy_end);
            exp_stall = !rst && (model_hazard(d, e, m) || (di.mdu_cls && exp_busy));
            @(negedge Clk);
            got = {En_PC, En_D, Clr_E, Busy};
            exp = {~exp_stall, ~exp_stall, exp_stall, exp_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc %0d D=%h E=%h M=%h rst=%0d {En_PC,En_D,Clr_E,Busy}=%b expected %b",
                         cyc, d, e, m, rst, got, exp);
            end
            tick();
            if (rst) begin
                d = '0; e = '0; m = '0;
                busy_end = -1;
            end else begin
                if (ei.md) busy_end = cyc + ei.lat;
                m = e;
                if (exp_stall) begin
                    e = '0;
                end else begin
                    e = d;
                    d = rand_ins();
                end
            end
        end
        Reset = 1'b0;
        IR_D = '0; IR_E = '0; IR_M = '0;
    endtask

    initial begin
        Reset = 1'b1;
        IR_D = '0; IR_E = '0; IR_M = '0;
        tick();
        test_reset();
        test_directed();
        test_mdu_latency(1'b1);
        test_mdu_latency(1'b0);
        test_reset_mid_count();
        test_random_pipeline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. It decodes the instructions held in the D, E and M pipeline registers and detects read-after-write hazards that forwarding cannot cover, using Tuse/Tnew rules. On a hazard it freezes PC and the D register and flushes E. With the MDU option compiled in, it also owns a multi-cycle mult/div busy counter that stalls HI/LO-class instructions.

## Interface
- No parameters. Opcode/funct constants come from the shared package.
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IR_D  in  32  instruction at D-register output.
- IR_E  in  32  instruction at E-register output.
- IR_M  in  32  instruction at M-register output.
- En_PC  out  1  PC write enable; 0 = hold PC.
- En_D  out  1  D-register En; 0 = hold IR_D/PC4_D.
- Clr_E  out  1  synchronous clear of E register (inserts nop).
- Busy  out  1  MDU busy indicator. Constant 0 when MDU_STALL_EN is undefined.

## Operation
- Decode each stage into classes:
  - cal_r: addu, subu, and, or, slt, sltu, sll
  - cal_i: ori, lui, addiu
  - ld: lw
  - st: sw
  - br: beq, bne
  - jr
  - jal
  - jalr
  - md: mult, multu, div, divu
  - mf: mfhi, mflo
  - mt: mthi, mtlo
  - Anything else is treated as a nop: no reads, no writes.
- Tuse in D:
  - br: rs=0, rt=0
  - jr, jalr: rs=0
  - cal_r, md: rs=1, rt=1
  - cal_i, ld, mt: rs=1
  - st: rs=1, rt=2
- Destination register:
  - cal_r, jalr, mf: rd
  - cal_i, ld: rt
  - jal: 31
  - all others: none
- Tnew in E:
  - cal_r, cal_i, mf: 1
  - ld: 2
  - jal, jalr: 0
- Tnew in M:
  - ld: 1
  - all others: 0
- Hazard stall: the D instruction reads register r, with r != 0, and r equals the destination of E (or M), and Tuse < Tnew of that stage.
- MDU stall (MDU_STALL_EN only): IR_D is md/mf/mt and Busy=1.
- stall = hazard stall | MDU stall. Output encoding:
  - stall=1: En_PC=0, En_D=0, Clr_E=1
  - stall=0: En_PC=1, En_D=1, Clr_E=0

## Timing
- En_PC, En_D, Clr_E and Busy are combinational from IR_D/IR_E/IR_M and the count register. They must settle in the same cycle.
- MDU count register, 4 bits, reset 0. At each rising edge, in priority order:
  1. Reset: clear to 0.
  2. IR_E is mult/multu: load 5.
  3. IR_E is div/divu: load 10.
  4. count != 0: decrement by 1.
  5. Otherwise hold 0. Never wraps below 0.
- Busy = (count != 0) | (IR_E is md). Busy is therefore high for 1+5 cycles (mult) or 1+10 cycles (div).
- A back-to-back md cannot occur, because the second one is stalled in D while the first is in E.
- While Reset=1:
  - Outputs are forced to En_PC=1, En_D=1, Clr_E=0, Busy=0.
  - The pipeline registers clear themselves and the count clears.
- Reset mid-count: count is 0 on the next cycle, and no stall is issued.
- All-zero IR (sll $0,$0,0) in every stage produces no stall.

## Configuration
- MDU_STALL_EN defined:
  - The count register, Busy generation and the MDU stall term are present.
- MDU_STALL_EN undefined:
  - No count register is synthesised and Busy is tied to 0.
  - md, mf and mt are still decoded for Tuse/Tnew; mf still writes rd.
  - Stalls come from register hazards only.

## Structure
- Shared package holds:
  - opcode and funct constants
  - class encoding
  - Tuse/Tnew constants
  - MDU latencies: MULT_CYC=5, DIV_CYC=10
- Sub-module instr_class: a pure decoder, IR to {class, rs, rt, dst}, instantiated three times (D, E, M).
- The top level holds the stall compare logic and the MDU counter.

## Test plan
- E=lw $1,0($0), D=addu $2,$1,$3 -> En_PC=0, En_D=0, Clr_E=1 for one cycle. The following cycle, with lw in M, stall=0.
- E=addu $1,$2,$3, D=beq $1,$0 -> stall for 1 cycle. Next cycle E=nop, M=addu; beq Tuse 0 vs M Tnew 0 -> no stall.
- E=lw $4, D=sw $4,0($5) -> no stall (rt Tuse 2 ≥ Tnew 2). D=sw $5,0($4) instead -> stall.
- Destination $0: E=lw $0, D=addu $2,$0,$0 -> no stall.
- MDU_STALL_EN: E=div, D=mflo $2 -> Busy=1 and stall for 11 cycles; Busy falls on the 12th and mflo proceeds. With mult: 6 cycles.
- Reset asserted at count=7 -> next cycle count=0, Busy=0, En_D=1.
